// File: rtl/fetch_aligner.sv
// Word-fetch to instruction aligner: buffers IMEM words as halfwords and presents one
// RVC or 32-bit instruction per handshake. `FETCH_ALIGNER_ILLEGAL_EN adds inst_illegal.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        is_compressed
`ifdef FETCH_ALIGNER_ILLEGAL_EN
    ,
    output logic        inst_illegal
`endif
);

    // F_IDLE: may issue a fetch | F_WAIT: fetch outstanding | F_DISCARD: stale fetch outstanding
    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_WAIT    = 2'd1,
        F_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [47:0] queue_q, queue_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        drop_low_q, drop_low_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic [15:0] head_hw;
    logic        head_is_c;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [1:0]  cnt_after;
    logic [47:0] push_bits;
    logic [47:0] q_shift;

    assign head_hw   = queue_q[15:0];
    assign head_is_c = (head_hw[1:0] != 2'b11);

    // Slots at or above count are kept zero, so an empty queue presents all-zero outputs.
    assign inst_valid    = ((count_q != 2'd0) && head_is_c) || ((count_q >= 2'd2) && !head_is_c);
    assign is_compressed = (count_q != 2'd0) && head_is_c;
    assign inst_o        = head_is_c ? {16'h0000, head_hw} : queue_q[31:0];
    assign inst_pc       = head_pc_q;
    assign imem_req      = req_q;
    assign imem_addr     = addr_q;

`ifdef FETCH_ALIGNER_ILLEGAL_EN
    assign inst_illegal = inst_valid & is_compressed & (head_hw == 16'h0000);
`endif

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        drop_low_d   = drop_low_q;
        req_d        = 1'b0;
        addr_d       = addr_q;
        pop_n        = 2'd0;
        push_n       = 2'd0;
        push_bits    = 48'h0;

        if (inst_valid && inst_ready) begin
            pop_n = head_is_c ? 2'd1 : 2'd2;
        end

        case (state_q)
            F_IDLE: begin
                if (count_q <= 2'd1) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_addr_q;
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (imem_rvalid) begin
                    fetch_addr_d = fetch_addr_q + 32'd4;
                    state_d      = F_IDLE;
                    if (drop_low_q) begin
                        push_bits  = {32'h0, imem_rdata[31:16]};
                        push_n     = 2'd1;
                        drop_low_d = 1'b0;
                    end else begin
                        push_bits = {16'h0, imem_rdata};
                        push_n    = 2'd2;
                    end
                end
            end
            F_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase

        q_shift   = queue_q >> {pop_n, 4'b0000};
        cnt_after = count_q - pop_n;
        queue_d   = q_shift | (push_bits << {cnt_after, 4'b0000});
        count_d   = cnt_after + push_n;
        head_pc_d = head_pc_q + {29'h0, pop_n, 1'b0};

        // Redirect overrides everything, including a same-cycle handshake or response.
        if (flush) begin
            queue_d      = 48'h0;
            count_d      = 2'd0;
            head_pc_d    = flush_pc;
            fetch_addr_d = {flush_pc[31:2], 2'b00};
            drop_low_d   = flush_pc[1];
            req_d        = 1'b0;
            addr_d       = addr_q;
            if (((state_q == F_WAIT) || (state_q == F_DISCARD)) && !imem_rvalid) begin
                state_d = F_DISCARD;
            end else begin
                state_d = F_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= F_IDLE;
            queue_q      <= 48'h0;
            count_q      <= 2'd0;
            head_pc_q    <= RESET_PC;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            drop_low_q   <= RESET_PC[1];
            req_q        <= 1'b0;
            addr_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            queue_q      <= queue_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_low_q   <= drop_low_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner with a behavioural IMEM of configurable latency.
// Build with FETCH_ALIGNER_ILLEGAL_EN defined to cover inst_illegal.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic        is_compressed;
`ifdef FETCH_ALIGNER_ILLEGAL_EN
    logic        inst_illegal;
`endif

    int n_checks = 0;
    int n_fail = 0;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .inst_o        (inst_o),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .is_compressed (is_compressed)
`ifdef FETCH_ALIGNER_ILLEGAL_EN
        ,
        .inst_illegal  (inst_illegal)
`endif
    );

    always #5 clk = ~clk;

    // IMEM model: answers each request mem_lat cycles later, driven on the falling edge.
    logic [31:0] mem [0:255];
    int          mem_lat = 1;
    bit          pend = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] req_log [$];

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (wait_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem[pend_addr[9:2]];
                    pend        = 1'b0;
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
            if (imem_req === 1'b1) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                wait_cnt  = mem_lat - 1;
                req_log.push_back(imem_addr);
            end
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b1;
        mem_lat    = 1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
        repeat (2) @(negedge clk);
        req_log.delete();
    endtask

    // Waits (bounded) for the next cycle with inst_valid high; ok=0 on timeout.
    task automatic next_inst(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset imem_req: got %b expected 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset imem_addr: got %h expected 0", imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset inst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset inst_o: got %h expected 0", inst_o); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset inst_pc: got %h expected 0", inst_pc); end
        n_checks++; if (is_compressed !== 1'b0) begin n_fail++; $display("FAIL reset is_compressed: got %b expected 0", is_compressed); end
    endtask

    task automatic test_full_word();
        do_reset();
        mem[0] = 32'h00B5_0513;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first addr: got %h expected 0", imem_addr); end
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL latency early valid: got %b expected 0", inst_valid); end
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL latency valid cycle2: got %b expected 1", inst_valid); end
        n_checks++; if (inst_o !== 32'h00B5_0513) begin n_fail++; $display("FAIL full inst_o: got %h expected 00b50513", inst_o); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL full inst_pc: got %h expected 0", inst_pc); end
        n_checks++; if (is_compressed !== 1'b0) begin n_fail++; $display("FAIL full is_compressed: got %b expected 0", is_compressed); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (req_log.size() < 2) begin
            n_fail++; $display("FAIL second req: got %0d requests expected at least 2", req_log.size());
        end else if (req_log[1] !== 32'h4) begin
            n_fail++; $display("FAIL second req addr: got %h expected 4", req_log[1]);
        end
    endtask

    task automatic test_compressed_pair();
        logic [31:0] ei [2] = '{32'h0000_0505, 32'h0000_4581};
        logic [31:0] ep [2] = '{32'h0, 32'h2};
        bit ok;
        do_reset();
        mem[0] = 32'h4581_0505;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_inst(ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL pair[%0d] timeout: got no inst_valid expected one", i);
            end else begin
                n_checks++; if (inst_o !== ei[i]) begin n_fail++; $display("FAIL pair[%0d] inst_o: got %h expected %h", i, inst_o, ei[i]); end
                n_checks++; if (inst_pc !== ep[i]) begin n_fail++; $display("FAIL pair[%0d] inst_pc: got %h expected %h", i, inst_pc, ep[i]); end
                n_checks++; if (is_compressed !== 1'b1) begin n_fail++; $display("FAIL pair[%0d] is_compressed: got %b expected 1", i, is_compressed); end
            end
        end
    endtask

    task automatic test_straddle();
        logic [31:0] ei [3] = '{32'h0000_4505, 32'h00B5_0513, 32'h0000_4581};
        logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h6};
        logic        ec [3] = '{1'b1, 1'b0, 1'b1};
        bit ok;
        do_reset();
        mem[0] = 32'h0513_4505;
        mem[1] = 32'h4581_00B5;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_inst(ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL straddle[%0d] timeout: got no inst_valid expected one", i);
            end else begin
                n_checks++; if (inst_o !== ei[i]) begin n_fail++; $display("FAIL straddle[%0d] inst_o: got %h expected %h", i, inst_o, ei[i]); end
                n_checks++; if (inst_pc !== ep[i]) begin n_fail++; $display("FAIL straddle[%0d] inst_pc: got %h expected %h", i, inst_pc, ep[i]); end
                n_checks++; if (is_compressed !== ec[i]) begin n_fail++; $display("FAIL straddle[%0d] is_compressed: got %b expected %b", i, is_compressed, ec[i]); end
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        mem_lat  = 4;
        mem[0]   = 32'h0513_4505;
        mem[64]  = 32'h4581_0505;
        mem[65]  = 32'h0001_0001;
        mem[128] = 32'h00B5_0513;
        rst_n = 1'b1;
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = 32'h0000_0102;
        @(negedge clk);
        flush = 1'b0;
        req_log.delete();
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush valid after: got %b expected 0", inst_valid); end
        next_inst(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL flush first timeout: got no inst_valid expected one");
        end else begin
            n_checks++; if (inst_o !== 32'h0000_4581) begin n_fail++; $display("FAIL flush first inst_o: got %h expected 00004581", inst_o); end
            n_checks++; if (inst_pc !== 32'h0000_0102) begin n_fail++; $display("FAIL flush first inst_pc: got %h expected 00000102", inst_pc); end
            n_checks++;
            if (req_log.size() < 1) begin
                n_fail++; $display("FAIL flush req: got 0 requests expected 1");
            end else if (req_log[0] !== 32'h0000_0100) begin
                n_fail++; $display("FAIL flush req addr: got %h expected 00000100", req_log[0]);
            end
        end
        next_inst(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL flush second timeout: got no inst_valid expected one");
        end else begin
            n_checks++; if (inst_pc !== 32'h0000_0104) begin n_fail++; $display("FAIL flush second inst_pc: got %h expected 00000104", inst_pc); end
            n_checks++; if (inst_o !== 32'h0000_0001) begin n_fail++; $display("FAIL flush second inst_o: got %h expected 00000001", inst_o); end
        end
        // Redirect while an instruction is being accepted: that handshake must not count.
        flush    = 1'b1;
        flush_pc = 32'h0000_0200;
        @(negedge clk);
        flush = 1'b0;
        next_inst(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL flush2 timeout: got no inst_valid expected one");
        end else begin
            n_checks++; if (inst_o !== 32'h00B5_0513) begin n_fail++; $display("FAIL flush2 inst_o: got %h expected 00b50513", inst_o); end
            n_checks++; if (inst_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL flush2 inst_pc: got %h expected 00000200", inst_pc); end
            n_checks++; if (is_compressed !== 1'b0) begin n_fail++; $display("FAIL flush2 is_compressed: got %b expected 0", is_compressed); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ei [4] = '{32'h0000_4581, 32'h00B5_0513, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] ep [4] = '{32'h2, 32'h4, 32'h8, 32'hA};
        bit ok;
        do_reset();
        inst_ready = 1'b0;
        mem[0] = 32'h4581_0505;
        mem[1] = 32'h00B5_0513;
        rst_n = 1'b1;
        next_inst(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL stall timeout: got no inst_valid expected one");
        end else begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                n_checks++; if (inst_o !== 32'h0000_0505) begin n_fail++; $display("FAIL stall[%0d] inst_o: got %h expected 00000505", c, inst_o); end
                n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL stall[%0d] inst_pc: got %h expected 0", c, inst_pc); end
            end
            n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL stall requests: got %0d expected 1", req_log.size()); end
            inst_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                next_inst(ok);
                n_checks++;
                if (!ok) begin
                    n_fail++; $display("FAIL release[%0d] timeout: got no inst_valid expected one", i);
                end else begin
                    n_checks++; if (inst_o !== ei[i]) begin n_fail++; $display("FAIL release[%0d] inst_o: got %h expected %h", i, inst_o, ei[i]); end
                    n_checks++; if (inst_pc !== ep[i]) begin n_fail++; $display("FAIL release[%0d] inst_pc: got %h expected %h", i, inst_pc, ep[i]); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ei [5] = '{32'h0000_0505, 32'h0000_4581, 32'h0000_4685, 32'h0000_4605, 32'h00B5_0513};
        logic [31:0] ep [5] = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h8};
        bit ok;
        do_reset();
        mem[0] = 32'h4581_0505;
        mem[1] = 32'h4605_4685;
        mem[2] = 32'h00B5_0513;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_inst(ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL b2b[%0d] timeout: got no inst_valid expected one", i);
            end else begin
                n_checks++; if (inst_o !== ei[i]) begin n_fail++; $display("FAIL b2b[%0d] inst_o: got %h expected %h", i, inst_o, ei[i]); end
                n_checks++; if (inst_pc !== ep[i]) begin n_fail++; $display("FAIL b2b[%0d] inst_pc: got %h expected %h", i, inst_pc, ep[i]); end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL midreset inst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL midreset inst_pc: got %h expected 0", inst_pc); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midreset imem_req: got %b expected 0", imem_req); end
    endtask

    task automatic test_zero_halfwords();
        logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h4};
        logic [31:0] ei [3] = '{32'h0, 32'h0, 32'h1};
        bit ok;
        do_reset();
        mem[0] = 32'h0000_0000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_inst(ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL zero[%0d] timeout: got no inst_valid expected one", i);
            end else begin
                n_checks++; if (inst_o !== ei[i]) begin n_fail++; $display("FAIL zero[%0d] inst_o: got %h expected %h", i, inst_o, ei[i]); end
                n_checks++; if (inst_pc !== ep[i]) begin n_fail++; $display("FAIL zero[%0d] inst_pc: got %h expected %h", i, inst_pc, ep[i]); end
                n_checks++; if (is_compressed !== 1'b1) begin n_fail++; $display("FAIL zero[%0d] is_compressed: got %b expected 1", i, is_compressed); end
`ifdef FETCH_ALIGNER_ILLEGAL_EN
                n_checks++;
                if (inst_illegal !== (i < 2)) begin
                    n_fail++; $display("FAIL zero[%0d] inst_illegal: got %b expected %b", i, inst_illegal, (i < 2));
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_compressed_pair();
        test_straddle();
        test_flush();
        test_stall();
        test_back_to_back();
        test_zero_halfwords();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
